// File: rtl/vec_proc_pkg.sv
// -----------------------------------------------------------------------------
// vec_proc_pkg
// Shared definitions for the result transmit path:
//   - tx_state_e    : serializer FSM states
//   - EN_*          : bit positions inside the one-hot operation select
//   - op_byte_count : number of result bytes an operation produces, clamped
//                     to the bytes available in the result word
// -----------------------------------------------------------------------------
package vec_proc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LOAD        = 3'd1,
      ST_START       = 3'd2,
      ST_WAIT_ACCEPT = 3'd3,
      ST_WAIT_DONE   = 3'd4,
      ST_DONE        = 3'd5
   } tx_state_e;

   localparam int unsigned EN_READ = 0;
   localparam int unsigned EN_SUM  = 1;
   localparam int unsigned EN_AVG  = 2;
   localparam int unsigned EN_EUC  = 3;
   localparam int unsigned EN_MAN  = 4;
   localparam int unsigned EN_DOT  = 5;

   // Caller guarantees en is one-hot; an all-zero select yields 0.
   function automatic logic [2:0] op_byte_count(input logic [5:0] en,
                                                input int         max_bytes);
      logic [2:0] n;
      n = 3'd0;
      if (en[EN_READ])                 n = 3'd1;
      else if (en[EN_SUM] | en[EN_AVG]) n = 3'd2;
      else if (en[EN_EUC] | en[EN_MAN]) n = 3'd3;
      else if (en[EN_DOT])              n = 3'd4;
      if (int'(n) > max_bytes) n = 3'(max_bytes);
      return n;
   endfunction

endpackage

// File: rtl/result_tx_serializer.sv
// -----------------------------------------------------------------------------
// result_tx_serializer
// Sends one result word over a byte-wide UART transmitter, MSB byte first.
// The number of bytes depends on the selected operation.
//
// Optional feature: define RESULT_TX_CHECKSUM_EN to append one XOR checksum
// byte (XOR of all payload bytes) after the payload.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high
//   tx_start      in   one-cycle request to send result_data
//   enables[5:0]  in   one-hot op select (read,sum,avg,euc,man,dot)
//   result_data   in   result word, valid with tx_start
//   tx_sent       out  one-cycle pulse when the whole result has been sent
//   uart_tx_start out  one-cycle load strobe for the UART transmitter
//   uart_tx_data  out  byte presented to the UART
//   uart_tx_busy  in   UART transmitter busy
//   sel_err       out  one-cycle pulse after a tx_start with a bad select
// -----------------------------------------------------------------------------
module result_tx_serializer
   import vec_proc_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_start,
   input  logic [5:0]        enables,
   input  logic [DATA_W-1:0] result_data,
   output logic              tx_sent,
   output logic              uart_tx_start,
   output logic [7:0]        uart_tx_data,
   input  logic              uart_tx_busy,
   output logic              sel_err
);

   localparam int MAX_BYTES = DATA_W / 8;

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [2:0]        cnt_q, cnt_d;      // payload byte count
   logic [2:0]        idx_q, idx_d;      // byte being sent
   logic              acc_q, acc_d;      // one idle cycle already seen in WAIT_ACCEPT
   logic              tx_sent_q, tx_sent_d;
   logic              sel_err_q, sel_err_d;
   logic              byte_done;
   logic [2:0]        byte_sel;
   logic [2:0]        total_bytes;
   logic [7:0]        payload_byte;
   logic [7:0]        tx_byte;
`ifdef RESULT_TX_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   // MSB first: byte index 0 is the highest byte of the low cnt*8 bits.
   assign byte_sel = cnt_q - idx_q - 3'd1;

   always_comb begin
      payload_byte = 8'h00;
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (3'(b) == byte_sel) payload_byte = word_q[b*8 +: 8];
      end
   end

`ifdef RESULT_TX_CHECKSUM_EN
   // The checksum byte follows the payload; csum_q is complete by the time
   // idx_q reaches cnt_q because it is folded in as each payload byte retires.
   assign total_bytes = cnt_q + 3'd1;
   assign tx_byte     = (idx_q == cnt_q) ? csum_q : payload_byte;
`else
   assign total_bytes = cnt_q;
   assign tx_byte     = payload_byte;
`endif

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      tx_sent_d = 1'b0;
      sel_err_d = 1'b0;
      byte_done = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               if ($onehot(enables)) begin
                  word_d  = result_data;
                  cnt_d   = op_byte_count(enables, MAX_BYTES);
                  idx_d   = 3'd0;
`ifdef RESULT_TX_CHECKSUM_EN
                  csum_d  = 8'h00;
`endif
                  state_d = ST_LOAD;
               end else begin
                  // Bad select: nothing is sent, error now, completion next.
                  sel_err_d = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            if (!uart_tx_busy) state_d = ST_START;
         end
         ST_START: begin
            acc_d   = 1'b0;
            state_d = ST_WAIT_ACCEPT;
         end
         ST_WAIT_ACCEPT: begin
            // A fast UART may finish before busy is ever seen; two idle
            // cycles here count as the byte being done.
            if (uart_tx_busy)  state_d   = ST_WAIT_DONE;
            else if (acc_q)    byte_done = 1'b1;
            else               acc_d     = 1'b1;
         end
         ST_WAIT_DONE: begin
            if (!uart_tx_busy) byte_done = 1'b1;
         end
         ST_DONE: begin
            tx_sent_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (byte_done) begin
         idx_d   = idx_q + 3'd1;
         acc_d   = 1'b0;
         state_d = ((idx_q + 3'd1) < total_bytes) ? ST_LOAD : ST_DONE;
`ifdef RESULT_TX_CHECKSUM_EN
         if (idx_q < cnt_q) csum_d = csum_q ^ payload_byte;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         word_q    <= '0;
         cnt_q     <= 3'd0;
         idx_q     <= 3'd0;
         acc_q     <= 1'b0;
         tx_sent_q <= 1'b0;
         sel_err_q <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
         csum_q    <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         tx_sent_q <= tx_sent_d;
         sel_err_q <= sel_err_d;
`ifdef RESULT_TX_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   // uart_tx_data follows the latched word and index, so it is stable for the
   // whole LOAD..WAIT_DONE span of each byte and zero after reset.
   assign uart_tx_start = (state_q == ST_START);
   assign uart_tx_data  = tx_byte;
   assign tx_sent       = tx_sent_q;
   assign sel_err       = sel_err_q;

endmodule

// File: tb/tb_result_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_result_tx_serializer
// Directed bench for result_tx_serializer (DATA_W = 32). A simple UART model
// inside the stimulus task raises busy for a fixed number of cycles after
// each uart_tx_start. Honors RESULT_TX_CHECKSUM_EN for expected byte counts.
// -----------------------------------------------------------------------------
module tb_result_tx_serializer;

`ifdef RESULT_TX_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_start;
   logic [5:0]  enables;
   logic [31:0] result_data;
   logic        tx_sent;
   logic        uart_tx_start;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_busy;
   logic        sel_err;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  cap  [0:7];
   int          t_st [0:7];
   int          ncap, nsent, nsel, t_sent, t_sel;
   logic        stable_ok;

   result_tx_serializer #(.DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .tx_start      (tx_start),
      .enables       (enables),
      .result_data   (result_data),
      .tx_sent       (tx_sent),
      .uart_tx_start (uart_tx_start),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_busy  (uart_tx_busy),
      .sel_err       (sel_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses tx_start at the current negedge, then runs ncyc cycles, recording
   // every uart_tx_start byte and cycle index (tx_start cycle = 0).
   task automatic run(input logic [5:0] en, input logic [31:0] data,
                      input int busy_len, input int ncyc,
                      input int rst_after, input int repulse_at);
      int busy_rem;
      busy_rem  = 0;
      ncap      = 0;
      nsent     = 0;
      nsel      = 0;
      t_sent    = -1;
      t_sel     = -1;
      stable_ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cap[k]  = 8'h00;
         t_st[k] = -1;
      end
      enables     = en;
      result_data = data;
      tx_start    = 1'b1;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         tx_start    = 1'b0;
         result_data = ~data;
         reset       = 1'b0;
         if (repulse_at == i) begin
            tx_start    = 1'b1;
            enables     = 6'b100000;
            result_data = 32'hFFFF_FFFF;
         end
         if (uart_tx_start) begin
            if (ncap < 8) begin
               cap[ncap]  = uart_tx_data;
               t_st[ncap] = i;
            end
            ncap++;
            busy_rem = busy_len;
         end else if (uart_tx_busy && ncap > 0 && ncap <= 8 && uart_tx_data !== cap[ncap-1]) begin
            stable_ok = 1'b0;
         end
         if (tx_sent) begin
            nsent++;
            t_sent = i;
         end
         if (sel_err) begin
            nsel++;
            t_sel = i;
         end
         if (rst_after > 0 && ncap == rst_after && i == t_st[rst_after-1] + 3) begin
            reset    = 1'b1;
            busy_rem = 0;
         end
         if (busy_rem > 0) begin
            uart_tx_busy = 1'b1;
            busy_rem--;
         end else begin
            uart_tx_busy = 1'b0;
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      tx_start     = 1'b0;
      enables      = 6'b000000;
      result_data  = 32'h0;
      uart_tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_sent",    32'(tx_sent),       32'h0);
      chk("rst_uart_start", 32'(uart_tx_start), 32'h0);
      chk("rst_sel_err",    32'(sel_err),       32'h0);
      chk("rst_uart_data",  32'(uart_tx_data),  32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Sum, busy 10 cycles per byte: byte period 12, first start at 2.
      run(6'b000010, 32'h0000_12AB, 10, 50, 0, 0);
      chk("sum_nbytes", 32'(ncap),    32'(2 + CS));
      chk("sum_b0",     32'(cap[0]),  32'h12);
      chk("sum_b1",     32'(cap[1]),  32'hAB);
      chk("sum_t0",     32'(t_st[0]), 32'd2);
      chk("sum_t1",     32'(t_st[1]), 32'd14);
      chk("sum_nsent",  32'(nsent),   32'd1);
      chk("sum_tsent",  32'(t_sent),  32'(2 + 12 * (2 + CS)));
      chk("sum_stable", 32'(stable_ok), 32'h1);
      chk("sum_nsel",   32'(nsel),    32'd0);
`ifdef RESULT_TX_CHECKSUM_EN
      chk("sum_csum",   32'(cap[2]),  32'hB9);
`endif

      // Dot, busy 3: byte period 5.
      run(6'b100000, 32'hDEAD_BEEF, 3, 40, 0, 0);
      chk("dot_nbytes", 32'(ncap),   32'(4 + CS));
      chk("dot_b0",     32'(cap[0]), 32'hDE);
      chk("dot_b1",     32'(cap[1]), 32'hAD);
      chk("dot_b2",     32'(cap[2]), 32'hBE);
      chk("dot_b3",     32'(cap[3]), 32'hEF);
      chk("dot_tsent",  32'(t_sent), 32'(2 + 5 * (4 + CS)));
      chk("dot_stable", 32'(stable_ok), 32'h1);
`ifdef RESULT_TX_CHECKSUM_EN
      chk("dot_csum",   32'(cap[4]), 32'h22);
`endif

      // Invalid multi-hot select.
      run(6'b000011, 32'h0000_00FF, 3, 10, 0, 0);
      chk("inv_nbytes", 32'(ncap),   32'd0);
      chk("inv_nsel",   32'(nsel),   32'd1);
      chk("inv_tsel",   32'(t_sel),  32'd1);
      chk("inv_nsent",  32'(nsent),  32'd1);
      chk("inv_tsent",  32'(t_sent), 32'd2);

      // Invalid all-zero select.
      run(6'b000000, 32'h0000_00FF, 3, 10, 0, 0);
      chk("zero_nbytes", 32'(ncap),  32'd0);
      chk("zero_nsel",   32'(nsel),  32'd1);
      chk("zero_tsent",  32'(t_sent), 32'd2);

      // Fast UART: busy never raised, byte period 4.
      run(6'b000001, 32'h0000_005A, 0, 20, 0, 0);
      chk("fast_nbytes", 32'(ncap),    32'(1 + CS));
      chk("fast_b0",     32'(cap[0]),  32'h5A);
      chk("fast_t0",     32'(t_st[0]), 32'd2);
      chk("fast_tsent",  32'(t_sent),  32'(2 + 4 * (1 + CS)));
      chk("fast_nsent",  32'(nsent),   32'd1);
`ifdef RESULT_TX_CHECKSUM_EN
      chk("fast_csum",   32'(cap[1]),  32'h5A);
`endif

      // Euc aborted by reset shortly after the second byte starts.
      run(6'b001000, 32'h0012_3456, 4, 40, 2, 0);
      chk("abort_nbytes", 32'(ncap),   32'd2);
      chk("abort_b1",     32'(cap[1]), 32'h34);
      chk("abort_nsent",  32'(nsent),  32'd0);

      // Euc after the abort: full transfer, byte period 6.
      run(6'b001000, 32'h0012_3456, 4, 40, 0, 0);
      chk("euc_nbytes", 32'(ncap),   32'(3 + CS));
      chk("euc_b0",     32'(cap[0]), 32'h12);
      chk("euc_b1",     32'(cap[1]), 32'h34);
      chk("euc_b2",     32'(cap[2]), 32'h56);
      chk("euc_nsent",  32'(nsent),  32'd1);
      chk("euc_tsent",  32'(t_sent), 32'(2 + 6 * (3 + CS)));
`ifdef RESULT_TX_CHECKSUM_EN
      chk("euc_csum",   32'(cap[3]), 32'h70);
`endif

      // tx_start re-pulsed (with a dot select and other data) mid-transfer.
      run(6'b000010, 32'h0000_12AB, 10, 50, 0, 5);
      chk("rep_nbytes", 32'(ncap),   32'(2 + CS));
      chk("rep_b0",     32'(cap[0]), 32'h12);
      chk("rep_b1",     32'(cap[1]), 32'hAB);
      chk("rep_nsent",  32'(nsent),  32'd1);
      chk("rep_tsent",  32'(t_sent), 32'(2 + 12 * (2 + CS)));
      chk("rep_nsel",   32'(nsel),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_tx_serializer.md
RESULT_TX_SERIALIZER -- requirements
Module: result_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result word width in bits (multiple of 8, 8..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port tx_start, input, 1, one-cycle request from the control unit to send one result.
REQ-005 SHALL have port enables, input, 6, one-hot operation select: bit0 read, bit1 sum, bit2 avg, bit3 euc, bit4 man, bit5 dot.
REQ-006 SHALL have port result_data, input, DATA_W, result word, valid in the cycle tx_start is high.
REQ-007 SHALL have port tx_sent, output, 1, one-cycle pulse when the whole result has left the UART.
REQ-008 SHALL have port uart_tx_start, output, 1, one-cycle pulse loading uart_tx_data into the UART transmitter.
REQ-009 SHALL have port uart_tx_data, output, 8, byte to transmit.
REQ-010 SHALL have port uart_tx_busy, input, 1, UART transmitter busy.
REQ-011 SHALL have port sel_err, output, 1, one-cycle pulse on tx_start with zero or multi-hot enables.

Function
REQ-012 Byte count by operation: read 1, sum 2, avg 2, euc 3, man 3, dot 4; counts above DATA_W/8 are clamped to DATA_W/8.
REQ-013 Bytes are sent MSB first, taken from the low (count*8) bits of result_data.
REQ-014 States are IDLE, LOAD, START, WAIT_ACCEPT, WAIT_DONE and DONE.
REQ-015 IDLE: on tx_start, latch result_data and the byte count, clear the byte index, go to LOAD; tx_start outside IDLE is ignored.
REQ-016 LOAD: drive uart_tx_data with the current byte; go to START once uart_tx_busy is low.
REQ-017 START: pulse uart_tx_start for exactly one cycle with stable uart_tx_data, then go to WAIT_ACCEPT.
REQ-018 WAIT_ACCEPT: on uart_tx_busy high, go to WAIT_DONE; after 2 cycles without busy, treat the byte as done (fast-UART tolerance).
REQ-019 WAIT_DONE: on uart_tx_busy low, increment the index; if bytes remain go to LOAD, else go to DONE.
REQ-020 DONE: pulse tx_sent for one cycle, return to IDLE; a tx_start in that same cycle is ignored.
REQ-021 With an invalid enables value on tx_start: send nothing, pulse sel_err in the next cycle, pulse tx_sent the cycle after that, return to IDLE.
REQ-022 Latency is 2 cycles from tx_start to the first uart_tx_start when uart_tx_busy is low.
REQ-023 uart_tx_data SHALL hold its value from LOAD through WAIT_DONE of each byte.

Reset
REQ-024 Reset SHALL force IDLE and clear tx_sent, uart_tx_start, sel_err, uart_tx_data, the byte index and the latched word.
REQ-025 Reset mid-transfer SHALL abort within one cycle; no tx_sent for the aborted result.

Configuration
REQ-026 With RESULT_TX_CHECKSUM_EN defined, one extra byte SHALL follow the payload: the XOR of all payload bytes, sent with the same LOAD..WAIT_DONE sequence before DONE.
REQ-027 Without RESULT_TX_CHECKSUM_EN, no checksum logic SHALL exist and only payload bytes are sent.
REQ-028 The invalid-enables path SHALL never send a checksum byte.

Structure
REQ-029 A shared package (vec_proc_pkg) SHALL hold: the state enum, the enables bit-position constants, and the per-operation byte-count function.
REQ-030 The block SHALL be a single module; no sub-module.

Verification
REQ-031 Sum: enables=6'b000010, result_data=32'h0000_12AB, UART busy 10 cycles per byte -> bytes 8'h12 then 8'hAB, one tx_sent after the second busy falls.
REQ-032 Dot: enables=6'b100000, result_data=32'hDEAD_BEEF -> bytes DE, AD, BE, EF; with RESULT_TX_CHECKSUM_EN, an extra byte 8'h22.
REQ-033 Invalid: enables=6'b000011 -> no uart_tx_start, sel_err pulse, then tx_sent one cycle later.
REQ-034 Fast UART: uart_tx_busy held low on read, result_data=8'h5A -> byte 5A, tx_sent 4 cycles after uart_tx_start.
REQ-035 Reset after the 2nd of 3 euc bytes -> no further uart_tx_start, no tx_sent; next tx_start sends all 3 bytes correctly.
REQ-036 tx_start re-pulsed mid-transfer -> ignored; byte count and data unchanged.
